sw_score_collector: RTL and testbench
=====================================

Name: sw_score_collector

Overview:
- Consumer end of the DNA_top matrix output interface.
- Captures each scored row presented on en/addr_matrix/matrix lanes 0..15 into a local row buffer.
- Tracks the global maximum Smith-Waterman cell score and its (row, lane) position.
- Exposes a registered host read port and a done flag. It sits between DNA_top and the host/traceback logic.

Parameters:
- LANES, 16: matrix lanes per row (matrix_o0..matrix_o15).
- SCORE_W, 32: width of one lane score, unsigned.
- DEPTH, 16: rows held in the row buffer, power of two.
- ADDR_W, 32: width of addr_matrix.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start_i  in  1  one-cycle pulse; clears state and arms collection
- num_rows_i  in  8  rows expected per alignment, sampled on start_i
- en_i  in  1  row valid strobe (from DNA_top en_o)
- addr_matrix_i  in  ADDR_W  row address (from addr_matrix_o)
- matrix_i  in  LANES*SCORE_W  lanes concatenated; lane k at bits [k*SCORE_W +: SCORE_W]
- rd_en_i  in  1  host read request
- rd_row_i  in  log2(DEPTH)  host read row
- rd_lane_i  in  4  host read lane
- rd_data_o  out  SCORE_W  buffered lane score
- rd_valid_o  out  1  rd_data_o valid
- max_score_o  out  SCORE_W  running maximum score
- max_row_o  out  ADDR_W  addr_matrix of the maximum row
- max_lane_o  out  4  lane index of the maximum
- busy_o  out  1  high in COLLECT
- done_o  out  1  high in DONE until the next start_i
- err_o  out  1  sticky: row address at or above DEPTH

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; row counter 0. Buffer contents are don't-care.
- FSM states: IDLE, COLLECT, DONE.
  - start_i from any state: clears max_score/row/lane, err_o and row_cnt, and latches num_rows_i.
    - Next state is COLLECT, or DONE if num_rows_i==0.
    - start_i takes priority over a simultaneous en_i; that row is dropped.
  - COLLECT, en_i=1: the row is accepted. row_cnt increments. When row_cnt+1==num_rows the next state is DONE.
  - en_i in IDLE or DONE: ignored, with no state change.
- Row capture:
  - Accepted row with addr < DEPTH: all lanes are written to buf[addr[log2(DEPTH)-1:0]] at the clock edge.
  - addr >= DEPTH: not stored; err_o set and held. The row still counts toward row_cnt and max tracking.
- Max tracking:
  - Combinational row maximum over the lanes, unsigned compare. Ties resolve to the lowest lane.
  - The global maximum updates at the same edge only if row_max > max_score_o (strict). Ties keep the earlier row.
  - Latency: max_* outputs reflect a row one cycle after its en_i. done_o rises on the same edge the final row's max is registered.
- Host read port:
  - rd_en_i samples rd_row_i/rd_lane_i. rd_data_o and rd_valid_o follow the next cycle.
  - rd_valid_o is a 1-cycle pulse per rd_en_i.
  - Back-to-back reads are allowed at one per cycle.
  - Reads are legal in any state. A read of a row written in the same cycle returns the old data (read-before-write).
- busy_o = (state==COLLECT). done_o = (state==DONE).
- Reset mid-COLLECT aborts immediately; the next alignment needs start_i.

Decomposition:
- Package sw_pkg holds:
  - localparams LANES, SCORE_W, LANE_IDX_W=4;
  - state typedef {IDLE, COLLECT, DONE};
  - function lane_slice(vector, k).
- Sub-module sw_row_max: purely combinational LANES-input unsigned max tree. It outputs row_max and lane index, with lowest-lane tie-break.

Test Plan:
- Reset then idle: rst low 3 cycles, release → all outputs 0, busy_o=0, done_o=0. en_i pulses while IDLE → no change.
- Basic run: start_i with num_rows_i=3; rows at addr 0,1,2 with lane5=7, lane9=12, lane0=4 respectively, other lanes 0 → done_o high one cycle after the third en_i; max_score_o=12, max_row_o=1, max_lane_o=9. Reading row1/lane9 → rd_data_o=12 one cycle later with rd_valid_o=1.
- Ties: rows 0 and 1 both have lanes 3 and 6 equal to 20 → max_row_o=0, max_lane_o=3.
- Out of range: with DEPTH=16, a row at addr 20 with lane2=50 → err_o=1 sticky, max_score_o=50, max_row_o=20. Reading buffer row 4 returns the prior contents.
- Restart and priority:
  - start_i mid-COLLECT → max cleared, row_cnt 0, err_o 0.
  - start_i coincident with en_i → that row is ignored.
  - num_rows_i=0 → done_o the cycle after start_i.
- Async reset mid-run: rst asserted between clock edges during COLLECT → outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared types, widths and lane helper for the score collector
//
// Purpose : lane geometry of the DNA_top matrix interface, FSM state type,
//           and a helper that extracts one lane score from a packed row.
// Ports   : none (package)

package sw_pkg;

   localparam int LANES      = 16;
   localparam int SCORE_W    = 32;
   localparam int LANE_IDX_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } state_t;

   // Lane k occupies bits [k*SCORE_W +: SCORE_W] of a packed row.
   function automatic logic [SCORE_W-1:0] lane_slice(
      input logic [LANES*SCORE_W-1:0] vec,
      input logic [LANE_IDX_W-1:0]    k
   );
      return vec[k*SCORE_W +: SCORE_W];
   endfunction

endpackage

// File: rtl/sw_row_max.sv
// rtl/sw_row_max.sv - combinational unsigned maximum over all lanes of one row
//
// Purpose : finds the largest lane score in a row and the lane it came from.
//           On equal scores the lowest lane index wins.
// Ports   : i_matrix    in  LANES*SCORE_W  packed row, lane k at [k*SCORE_W +: SCORE_W]
//           o_row_max   out SCORE_W        largest lane score
//           o_row_lane  out LANE_IDX_W     lane index of o_row_max

module sw_row_max
   import sw_pkg::*;
(
   input  logic [LANES*SCORE_W-1:0] i_matrix,
   output logic [SCORE_W-1:0]       o_row_max,
   output logic [LANE_IDX_W-1:0]    o_row_lane
);

   logic [SCORE_W-1:0]    w_best;
   logic [LANE_IDX_W-1:0] w_best_idx;

   // Scan upward with a strict compare so a later equal lane never replaces
   // an earlier one.
   always_comb begin
      w_best     = lane_slice(i_matrix, '0);
      w_best_idx = '0;
      for (int k = 1; k < LANES; k++) begin
         if (lane_slice(i_matrix, LANE_IDX_W'(k)) > w_best) begin
            w_best     = lane_slice(i_matrix, LANE_IDX_W'(k));
            w_best_idx = LANE_IDX_W'(k);
         end
      end
   end

   assign o_row_max  = w_best;
   assign o_row_lane = w_best_idx;

endmodule

// File: rtl/sw_score_collector.sv
// rtl/sw_score_collector.sv - captures scored rows, tracks the global maximum, serves host reads
//
// Purpose : consumer of the DNA_top matrix output. Buffers each accepted row,
//           keeps the running maximum cell score with its (row, lane), and
//           offers a registered host read port plus busy/done/err status.
// Ports   : clk, rst (async active-low)
//           start_i, num_rows_i          arm a new alignment of num_rows_i rows
//           en_i, addr_matrix_i, matrix_i row strobe, row address, packed lanes
//           rd_en_i, rd_row_i, rd_lane_i host read request
//           rd_data_o, rd_valid_o        read result, one cycle after rd_en_i
//           max_score_o, max_row_o, max_lane_o running maximum and its position
//           busy_o, done_o, err_o        status (err_o sticky until start_i)

module sw_score_collector
   import sw_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start_i,
   input  logic [7:0]                 num_rows_i,
   input  logic                       en_i,
   input  logic [ADDR_W-1:0]          addr_matrix_i,
   input  logic [LANES*SCORE_W-1:0]   matrix_i,
   input  logic                       rd_en_i,
   input  logic [$clog2(DEPTH)-1:0]   rd_row_i,
   input  logic [LANE_IDX_W-1:0]      rd_lane_i,
   output logic [SCORE_W-1:0]         rd_data_o,
   output logic                       rd_valid_o,
   output logic [SCORE_W-1:0]         max_score_o,
   output logic [ADDR_W-1:0]          max_row_o,
   output logic [LANE_IDX_W-1:0]      max_lane_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       err_o
);

   localparam int ROW_W = $clog2(DEPTH);

   state_t                  r_state;
   state_t                  w_next;
   logic [7:0]              r_num_rows;
   logic [7:0]              r_row_cnt;
   logic [SCORE_W-1:0]      r_max_score;
   logic [ADDR_W-1:0]       r_max_row;
   logic [LANE_IDX_W-1:0]   r_max_lane;
   logic                    r_err;
   logic [SCORE_W-1:0]      r_rd_data;
   logic                    r_rd_valid;
   logic [LANES*SCORE_W-1:0] r_buf [DEPTH];

   logic [SCORE_W-1:0]      w_row_max;
   logic [LANE_IDX_W-1:0]   w_row_lane;
   logic                    w_accept;
   logic                    w_last;
   logic                    w_in_range;

   sw_row_max u_row_max (
      .i_matrix   (matrix_i),
      .o_row_max  (w_row_max),
      .o_row_lane (w_row_lane)
   );

   // start_i wins over a coincident en_i, so that row is never accepted.
   assign w_accept   = (r_state == COLLECT) && en_i && !start_i;
   assign w_last     = ({1'b0, r_row_cnt} + 9'd1) == {1'b0, r_num_rows};
   assign w_in_range = addr_matrix_i < ADDR_W'(DEPTH);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      if (start_i) begin
         w_next = (num_rows_i == 8'd0) ? DONE : COLLECT;
      end else if (w_accept && w_last) begin
         w_next = DONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_num_rows  <= '0;
         r_row_cnt   <= '0;
         r_max_score <= '0;
         r_max_row   <= '0;
         r_max_lane  <= '0;
         r_err       <= 1'b0;
         r_rd_data   <= '0;
         r_rd_valid  <= 1'b0;
      end else begin
         r_rd_valid <= rd_en_i;
         // Sampled from the pre-edge buffer, so a same-cycle write is not seen.
         if (rd_en_i) begin
            r_rd_data <= lane_slice(r_buf[rd_row_i], rd_lane_i);
         end

         if (start_i) begin
            r_num_rows  <= num_rows_i;
            r_row_cnt   <= '0;
            r_max_score <= '0;
            r_max_row   <= '0;
            r_max_lane  <= '0;
            r_err       <= 1'b0;
         end else if (w_accept) begin
            r_row_cnt <= r_row_cnt + 8'd1;
            if (!w_in_range) begin
               r_err <= 1'b1;
            end
            // Strict compare: an equal score in a later row keeps the earlier one.
            if (w_row_max > r_max_score) begin
               r_max_score <= w_row_max;
               r_max_row   <= addr_matrix_i;
               r_max_lane  <= w_row_lane;
            end
         end
      end
   end

   // Buffer contents need no reset; out-of-range rows are not stored.
   always_ff @(posedge clk) begin
      if (w_accept && w_in_range) begin
         r_buf[addr_matrix_i[ROW_W-1:0]] <= matrix_i;
      end
   end

   assign rd_data_o   = r_rd_data;
   assign rd_valid_o  = r_rd_valid;
   assign max_score_o = r_max_score;
   assign max_row_o   = r_max_row;
   assign max_lane_o  = r_max_lane;
   assign err_o       = r_err;
   assign busy_o      = (r_state == COLLECT);
   assign done_o      = (r_state == DONE);

endmodule

// File: tb/tb_sw_score_collector.sv
// tb/tb_sw_score_collector.sv - directed self-checking bench for sw_score_collector

module tb_sw_score_collector;
   import sw_pkg::*;

   logic                     clk;
   logic                     rst;
   logic                     start_i;
   logic [7:0]               num_rows_i;
   logic                     en_i;
   logic [31:0]              addr_matrix_i;
   logic [LANES*SCORE_W-1:0] matrix_i;
   logic                     rd_en_i;
   logic [3:0]               rd_row_i;
   logic [3:0]               rd_lane_i;
   logic [SCORE_W-1:0]       rd_data_o;
   logic                     rd_valid_o;
   logic [SCORE_W-1:0]       max_score_o;
   logic [31:0]              max_row_o;
   logic [3:0]               max_lane_o;
   logic                     busy_o;
   logic                     done_o;
   logic                     err_o;

   int checks = 0;
   int errors = 0;

   sw_score_collector #(.DEPTH(16), .ADDR_W(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start_i),
      .num_rows_i    (num_rows_i),
      .en_i          (en_i),
      .addr_matrix_i (addr_matrix_i),
      .matrix_i      (matrix_i),
      .rd_en_i       (rd_en_i),
      .rd_row_i      (rd_row_i),
      .rd_lane_i     (rd_lane_i),
      .rd_data_o     (rd_data_o),
      .rd_valid_o    (rd_valid_o),
      .max_score_o   (max_score_o),
      .max_row_o     (max_row_o),
      .max_lane_o    (max_lane_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .err_o         (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_row(input logic [31:0] a, input int lane, input logic [31:0] v);
      matrix_i = '0;
      matrix_i[lane*SCORE_W +: SCORE_W] = v;
      addr_matrix_i = a;
      en_i = 1'b1;
   endtask

   task automatic send_row(input logic [31:0] a, input int lane, input logic [31:0] v);
      set_row(a, lane, v);
      tick();
      en_i = 1'b0;
   endtask

   task automatic do_start(input logic [7:0] n);
      start_i = 1'b1;
      num_rows_i = n;
      tick();
      start_i = 1'b0;
   endtask

   task automatic do_read(input logic [3:0] row, input logic [3:0] lane);
      rd_en_i = 1'b1;
      rd_row_i = row;
      rd_lane_i = lane;
      tick();
      rd_en_i = 1'b0;
   endtask

   task automatic chk_max(input string tag, input logic [31:0] s, input logic [31:0] r, input logic [3:0] l);
      chk({tag, "_score"}, 64'(max_score_o), 64'(s));
      chk({tag, "_row"},   64'(max_row_o),   64'(r));
      chk({tag, "_lane"},  64'(max_lane_o),  64'(l));
   endtask

   initial begin
      rst = 1'b0;
      start_i = 1'b0;
      num_rows_i = '0;
      en_i = 1'b0;
      addr_matrix_i = '0;
      matrix_i = '0;
      rd_en_i = 1'b0;
      rd_row_i = '0;
      rd_lane_i = '0;

      // Reset, then idle
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      tick();
      chk_max("rst", 0, 0, 0);
      chk("rst_busy", 64'(busy_o), 0);
      chk("rst_done", 64'(done_o), 0);
      chk("rst_err", 64'(err_o), 0);
      chk("rst_rdv", 64'(rd_valid_o), 0);
      chk("rst_rdd", 64'(rd_data_o), 0);
      send_row(0, 0, 99);
      chk_max("idle_en", 0, 0, 0);
      chk("idle_busy", 64'(busy_o), 0);

      // Basic run of three rows
      do_start(3);
      chk("basic_busy", 64'(busy_o), 1);
      send_row(0, 5, 7);
      chk_max("basic_r0", 7, 0, 5);
      send_row(1, 9, 12);
      chk("basic_r1_done", 64'(done_o), 0);
      send_row(2, 0, 4);
      chk("basic_done", 64'(done_o), 1);
      chk("basic_busy_low", 64'(busy_o), 0);
      chk_max("basic", 12, 1, 9);
      send_row(3, 1, 500);
      chk_max("done_en_ignored", 12, 1, 9);
      chk("done_hold", 64'(done_o), 1);
      do_read(1, 9);
      chk("rd_r1l9", 64'(rd_data_o), 12);
      chk("rd_r1l9_v", 64'(rd_valid_o), 1);
      rd_en_i = 1'b1; rd_row_i = 0; rd_lane_i = 5;
      tick();
      chk("rd_b2b_0", 64'(rd_data_o), 7);
      rd_row_i = 2; rd_lane_i = 0;
      tick();
      rd_en_i = 1'b0;
      chk("rd_b2b_1", 64'(rd_data_o), 4);
      chk("rd_b2b_v", 64'(rd_valid_o), 1);
      tick();
      chk("rd_v_pulse", 64'(rd_valid_o), 0);

      // Ties across lanes and rows
      do_start(2);
      chk_max("start_clear", 0, 0, 0);
      for (int r = 0; r < 2; r++) begin
         matrix_i = '0;
         matrix_i[3*SCORE_W +: SCORE_W] = 20;
         matrix_i[6*SCORE_W +: SCORE_W] = 20;
         addr_matrix_i = 32'(r);
         en_i = 1'b1;
         tick();
         en_i = 1'b0;
      end
      chk("tie_done", 64'(done_o), 1);
      chk_max("tie", 20, 0, 3);

      // Out-of-range row address
      do_start(2);
      send_row(4, 1, 33);
      chk("oor_err_pre", 64'(err_o), 0);
      send_row(20, 2, 50);
      chk("oor_err", 64'(err_o), 1);
      chk_max("oor", 50, 20, 2);
      do_read(4, 1);
      chk("oor_buf_kept", 64'(rd_data_o), 33);
      tick();
      chk("oor_err_sticky", 64'(err_o), 1);

      // Read-before-write on row 0 (lane 3 holds 20 from the tie run)
      do_start(1);
      set_row(0, 3, 77);
      rd_en_i = 1'b1; rd_row_i = 0; rd_lane_i = 3;
      tick();
      en_i = 1'b0;
      rd_en_i = 1'b0;
      chk("rbw_old", 64'(rd_data_o), 20);
      chk("rbw_done", 64'(done_o), 1);
      do_read(0, 3);
      chk("rbw_new", 64'(rd_data_o), 77);

      // Restart mid-collect with a coincident row
      do_start(3);
      send_row(30, 0, 5);
      chk("rs_err", 64'(err_o), 1);
      chk_max("rs_pre", 5, 30, 0);
      set_row(2, 0, 100);
      start_i = 1'b1;
      num_rows_i = 3;
      tick();
      start_i = 1'b0;
      en_i = 1'b0;
      chk_max("rs_clear", 0, 0, 0);
      chk("rs_err_clr", 64'(err_o), 0);
      chk("rs_busy", 64'(busy_o), 1);
      send_row(1, 4, 9);
      send_row(2, 4, 8);
      chk("rs_cnt_2", 64'(done_o), 0);
      send_row(3, 4, 1);
      chk("rs_cnt_3", 64'(done_o), 1);
      chk_max("rs", 9, 1, 4);

      // Zero-row alignment
      do_start(0);
      chk("zero_done", 64'(done_o), 1);
      chk("zero_busy", 64'(busy_o), 0);

      // Asynchronous reset between edges
      do_start(3);
      send_row(5, 7, 66);
      chk("ar_pre", 64'(max_score_o), 66);
      #2;
      rst = 1'b0;
      #1;
      chk("ar_busy", 64'(busy_o), 0);
      chk("ar_score", 64'(max_score_o), 0);
      chk("ar_row", 64'(max_row_o), 0);
      chk("ar_lane", 64'(max_lane_o), 0);
      tick();
      rst = 1'b1;
      tick();
      send_row(6, 1, 40);
      chk("ar_idle_ignore", 64'(max_score_o), 0);
      chk("ar_done", 64'(done_o), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
